// File: rtl/spi_path_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_path_arbiter
//  Description : Hands the single Raspberry SPI port back and forth between
//                the MATRIX core bridge (path 0) and the NFC module (path 1).
//                A switch waits for the bus to be idle, blanks both chip
//                selects for a guard interval, and is forced after a timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_path_arbiter #(
    parameter int unsigned IDLE_CYCLES    = 4,
    parameter int unsigned GUARD_CYCLES   = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel_req,
    input  logic       ss_i,
    output logic       ss_core_o,
    output logic       ss_nfc_o,
    output logic       path_sel,
    output logic       busy,
    output logic       abort,
    output logic [7:0] switch_cnt
);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_GUARD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_IDLE    = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] C_GUARD   = CNT_W'(GUARD_CYCLES);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] C_MAX     = '1;

    // Synchronizer stages: ss idles high, sel idles at core ownership
    logic ss_meta_q, ss_s_q;
    logic sel_meta_q, sel_s_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] guard_cnt_q, guard_cnt_d;
    logic             path_sel_q, path_sel_d;
    logic             abort_q, abort_d;
    logic [7:0]       switch_cnt_q, switch_cnt_d;

    logic [CNT_W-1:0] idle_inc, to_inc, guard_inc;
    logic             in_guard;

    // Saturating increments: internal counters stop at all-ones
    assign idle_inc  = (idle_cnt_q  == C_MAX) ? idle_cnt_q  : idle_cnt_q  + 1'b1;
    assign to_inc    = (to_cnt_q    == C_MAX) ? to_cnt_q    : to_cnt_q    + 1'b1;
    assign guard_inc = (guard_cnt_q == C_MAX) ? guard_cnt_q : guard_cnt_q + 1'b1;

    // Two-flop synchronizers for the asynchronous select request and chip select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_meta_q  <= 1'b1;
            ss_s_q     <= 1'b1;
            sel_meta_q <= 1'b0;
            sel_s_q    <= 1'b0;
        end else begin
            ss_meta_q  <= ss_i;
            ss_s_q     <= ss_meta_q;
            sel_meta_q <= sel_req;
            sel_s_q    <= sel_meta_q;
        end
    end

    // State, counters and published ownership
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_ACTIVE;
            idle_cnt_q   <= '0;
            to_cnt_q     <= '0;
            guard_cnt_q  <= '0;
            path_sel_q   <= 1'b0;
            abort_q      <= 1'b0;
            switch_cnt_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            to_cnt_q     <= to_cnt_d;
            guard_cnt_q  <= guard_cnt_d;
            path_sel_q   <= path_sel_d;
            abort_q      <= abort_d;
            switch_cnt_q <= switch_cnt_d;
        end
    end

    // Next-state logic: withdrawal beats idle completion, which beats timeout
    always_comb begin
        state_d      = state_q;
        idle_cnt_d   = idle_cnt_q;
        to_cnt_d     = to_cnt_q;
        guard_cnt_d  = guard_cnt_q;
        path_sel_d   = path_sel_q;
        abort_d      = 1'b0;
        switch_cnt_d = switch_cnt_q;
        case (state_q)
            ST_ACTIVE: begin
                if (sel_s_q != path_sel_q) begin
                    state_d    = ST_DRAIN;
                    idle_cnt_d = '0;
                    to_cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                to_cnt_d   = to_inc;
                idle_cnt_d = ss_s_q ? idle_inc : '0;
                if (sel_s_q == path_sel_q) begin
                    state_d = ST_ACTIVE;
                end else if (ss_s_q && (idle_inc >= C_IDLE)) begin
                    state_d     = ST_GUARD;
                    guard_cnt_d = '0;
                end else if (to_inc >= C_TIMEOUT) begin
                    state_d     = ST_GUARD;
                    guard_cnt_d = '0;
                    abort_d     = 1'b1;
                end
            end
            ST_GUARD: begin
                guard_cnt_d = guard_inc;
                if (guard_inc >= C_GUARD) begin
                    state_d    = ST_ACTIVE;
                    path_sel_d = sel_s_q;
                    if (sel_s_q != path_sel_q) begin
                        switch_cnt_d = switch_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_ACTIVE;
            end
        endcase
    end

    // Chip-select gating: only the owner sees ss, nobody during guard or reset
    assign in_guard   = (state_q == ST_GUARD);
    assign ss_core_o  = (rst || path_sel_q || in_guard) ? 1'b1 : ss_i;
    assign ss_nfc_o   = (rst || !path_sel_q || in_guard) ? 1'b1 : ss_i;

    assign path_sel   = path_sel_q;
    assign busy       = (state_q == ST_DRAIN) || in_guard;
    assign abort      = abort_q;
    assign switch_cnt = switch_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_path_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_path_arbiter
//  Description : Scoreboard bench for spi_path_arbiter. One instance uses the
//                default timeout, a second uses TIMEOUT_CYCLES=50.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_path_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel_req;
    logic       ss_i;
    logic       ss_core_o, ss_nfc_o, path_sel, busy, abort;
    logic [7:0] switch_cnt;
    logic       t_ss_core_o, t_ss_nfc_o, t_path_sel, t_busy, t_abort;
    logic [7:0] t_switch_cnt;

    spi_path_arbiter u_dut (
        .clk(clk), .rst(rst), .sel_req(sel_req), .ss_i(ss_i),
        .ss_core_o(ss_core_o), .ss_nfc_o(ss_nfc_o), .path_sel(path_sel),
        .busy(busy), .abort(abort), .switch_cnt(switch_cnt)
    );

    spi_path_arbiter #(.TIMEOUT_CYCLES(50)) u_dut_to (
        .clk(clk), .rst(rst), .sel_req(sel_req), .ss_i(ss_i),
        .ss_core_o(t_ss_core_o), .ss_nfc_o(t_ss_nfc_o), .path_sel(t_path_sel),
        .busy(t_busy), .abort(t_abort), .switch_cnt(t_switch_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic       p;
        logic [7:0] n;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  abort_cnt = 0;
    int  abort_to_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: pops an expected switch event whenever the main DUT's owner changes
    initial begin
        logic prev;
        ev_t  ev;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (abort === 1'b1)   abort_cnt++;
            if (t_abort === 1'b1) abort_to_cnt++;
            if (rst) begin
                prev = path_sel;
            end else if (path_sel !== prev) begin
                prev = path_sel;
                if (exp_q.size() == 0) begin
                    check("unexpected_switch", 32'd1, 32'd0);
                end else begin
                    ev = exp_q.pop_front();
                    check("switch_cycle", cyc, ev.c);
                    check("switch_path", {31'd0, path_sel}, {31'd0, ev.p});
                    check("switch_count", {24'd0, switch_cnt}, {24'd0, ev.n});
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        ss_i = 1'b0;
        #1;
        check("rst_ss_core", {31'd0, ss_core_o}, 32'd1);
        check("rst_ss_nfc", {31'd0, ss_nfc_o}, 32'd1);
        check("rst_path", {31'd0, path_sel}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_switch_cnt", {24'd0, switch_cnt}, 32'd0);
        repeat (3) @(negedge clk);
        ss_i    = 1'b1;
        sel_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int   t0, t1, a0;
        logic bad;
        rst = 1'b1; sel_req = 1'b0; ss_i = 1'b1;
        repeat (2) @(negedge clk);
        do_reset();
        check("init_abort", {31'd0, abort}, 32'd0);
        ss_i = 1'b0;
        #1;
        check("init_core_follows", {31'd0, ss_core_o}, 32'd0);
        check("init_nfc_blocked", {31'd0, ss_nfc_o}, 32'd1);
        ss_i = 1'b1;

        // 1: idle bus, switch to NFC in 15 cycles
        @(negedge clk);
        t0 = cyc; sel_req = 1'b1;
        exp_q.push_back('{t0 + 15, 1'b1, 8'd1});
        wait_cyc(t0 + 10);
        check("t1_busy", {31'd0, busy}, 32'd1);
        wait_cyc(t0 + 14);
        check("t1_path_early", {31'd0, path_sel}, 32'd0);
        wait_cyc(t0 + 20);
        ss_i = 1'b0;
        #1;
        check("t1_nfc_follows", {31'd0, ss_nfc_o}, 32'd0);
        check("t1_core_blocked", {31'd0, ss_core_o}, 32'd1);
        ss_i = 1'b1;

        // 2: frame active for 100 cycles, then idle 4 + guard 8 after sync
        @(negedge clk);
        t0 = cyc; ss_i = 1'b0; sel_req = 1'b0;
        wait_cyc(t0 + 99);
        check("t2_path_held", {31'd0, path_sel}, 32'd1);
        check("t2_busy", {31'd0, busy}, 32'd1);
        check("t2_frame_not_cut", {31'd0, ss_nfc_o}, 32'd0);
        wait_cyc(t0 + 100);
        t1 = cyc; ss_i = 1'b1;
        exp_q.push_back('{t1 + 14, 1'b0, 8'd2});
        wait_cyc(t1 + 13);
        check("t2_path_before_guard_end", {31'd0, path_sel}, 32'd1);
        wait_cyc(t1 + 20);
        do_reset();

        // 3: ss stuck low, timeout of 50 forces a switch (timeout instance)
        @(negedge clk);
        t0 = cyc; ss_i = 1'b0; sel_req = 1'b1; a0 = abort_to_cnt;
        wait_cyc(t0 + 52);
        check("t3_abort_early", {31'd0, t_abort}, 32'd0);
        check("t3_frame_live", {31'd0, t_ss_core_o}, 32'd0);
        check("t3_busy", {31'd0, t_busy}, 32'd1);
        wait_cyc(t0 + 53);
        check("t3_abort_pulse", {31'd0, t_abort}, 32'd1);
        check("t3_core_blank", {31'd0, t_ss_core_o}, 32'd1);
        check("t3_nfc_blank", {31'd0, t_ss_nfc_o}, 32'd1);
        wait_cyc(t0 + 60);
        check("t3_path_in_guard", {31'd0, t_path_sel}, 32'd0);
        check("t3_nfc_blank_end", {31'd0, t_ss_nfc_o}, 32'd1);
        wait_cyc(t0 + 61);
        check("t3_path_switched", {31'd0, t_path_sel}, 32'd1);
        check("t3_switch_cnt", {24'd0, t_switch_cnt}, 32'd1);
        check("t3_nfc_follows", {31'd0, t_ss_nfc_o}, 32'd0);
        check("t3_abort_done", {31'd0, t_abort}, 32'd0);
        wait_cyc(t0 + 70);
        check("t3_abort_once", abort_to_cnt - a0, 32'd1);
        check("t3_main_still_core", {31'd0, path_sel}, 32'd0);
        do_reset();

        // 4: request withdrawn inside DRAIN
        @(negedge clk);
        t0 = cyc; sel_req = 1'b1;
        @(negedge clk);
        sel_req = 1'b0;
        wait_cyc(t0 + 3);
        check("t4_busy_drain", {31'd0, busy}, 32'd1);
        wait_cyc(t0 + 4);
        check("t4_back_active", {31'd0, busy}, 32'd0);
        ss_i = 1'b0;
        bad = 1'b0;
        for (int k = 5; k <= 15; k++) begin
            wait_cyc(t0 + k);
            if (ss_core_o !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        check("t4_no_blanking", {31'd0, bad}, 32'd0);
        check("t4_path", {31'd0, path_sel}, 32'd0);
        check("t4_switch_cnt", {24'd0, switch_cnt}, 32'd0);
        ss_i = 1'b1;

        // 5: reset asserted mid-GUARD
        @(negedge clk);
        t0 = cyc; sel_req = 1'b1;
        wait_cyc(t0 + 9);
        ss_i = 1'b0;
        #1;
        check("t5_guard_busy", {31'd0, busy}, 32'd1);
        check("t5_guard_core_blank", {31'd0, ss_core_o}, 32'd1);
        check("t5_guard_nfc_blank", {31'd0, ss_nfc_o}, 32'd1);
        @(negedge clk);
        rst = 1'b1; sel_req = 1'b0;
        #1;
        check("t5_rst_core", {31'd0, ss_core_o}, 32'd1);
        check("t5_rst_nfc", {31'd0, ss_nfc_o}, 32'd1);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        ss_i = 1'b1;
        rst  = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_post_path", {31'd0, path_sel}, 32'd0);
        check("t5_post_busy", {31'd0, busy}, 32'd0);
        check("t5_post_cnt", {24'd0, switch_cnt}, 32'd0);

        // 6: 256 completed toggles wrap the switch counter
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            t0 = cyc;
            sel_req = ~sel_req;
            exp_q.push_back('{t0 + 15, sel_req, 8'(i + 1)});
            repeat (19) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check("t6_cnt_wrapped", {24'd0, switch_cnt}, 32'd0);
        check("t6_path_final", {31'd0, path_sel}, {31'd0, sel_req});

        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        check("main_never_aborted", abort_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
